// File: rtl/bist_pkg.sv
// Shared BIST definitions for the s9234 logic-BIST path.
// Holds the controller state type, the cycle-counter width and the default
// MISR polynomial and width, which the LFSR TPG also uses.
package bist_pkg;

    localparam int unsigned CYCLE_CNT_W = 24;

    localparam int unsigned             DEF_MISR_W    = 16;
    localparam logic [DEF_MISR_W-1:0]   DEF_MISR_POLY = 16'h1021;

    typedef enum logic [1:0] {
        StIdle,
        StSkip,
        StCompact,
        StDone
    } bist_state_e;

endpackage

// File: rtl/misr_core.sv
// Multiple-input signature register.
// Ports:
//   clk_i      clock, rising edge
//   rst_ni     asynchronous active-low reset (loads Seed)
//   clear_i    synchronous seed reload, wins over en_i
//   en_i       shift and compact data_i this cycle
//   data_i     parallel input, bit i XORed into signature bit i
//   sig_o      current signature
//   sig_next_o value the register takes on an enabled cycle
module misr_core #(
    parameter int unsigned     W    = 16,
    parameter logic [W-1:0]    Poly = 16'h1021,
    parameter logic [W-1:0]    Seed = '0
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clear_i,
    input  logic         en_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] sig_o,
    output logic [W-1:0] sig_next_o
);

    logic [W-1:0] sig_q, sig_d;

    always_comb begin
        sig_next_o = (sig_q << 1) ^ (sig_q[W-1] ? Poly : '0) ^ data_i;
        sig_d      = sig_q;
        if (clear_i) begin
            sig_d = Seed;
        end else if (en_i) begin
            sig_d = sig_next_o;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sig_q <= Seed;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig_o = sig_q;

endmodule

// File: rtl/bist_misr_compactor.sv
// Output response analyser: compacts the scan-chain outputs into a MISR,
// counts unload cycles, and compares the final signature with GOLDEN_SIG.
// Optional feature macro: MISR_XMASK_EN adds the xmask input port; masked
// chains contribute 0 to the MISR (mask is registered one cycle before use).
// Ports:
//   CK            clock, rising edge
//   COMP_reset_n  asynchronous active-low reset
//   bist_en       BIST mode enable
//   scan_en       shift enable; bist_en & scan_en marks an enable cycle
//   comp_clear    synchronous clear back to IDLE with seed loaded
//   so_chains     chain outputs, bit 0 = SO_chain1
//   xmask         (MISR_XMASK_EN only) per-chain X-block mask
//   signature     current MISR contents
//   bist_done     high in DONE
//   bist_pass     registered compare result, valid while bist_done
//   cycle_cnt     accepted enable cycles, including skipped ones
module bist_misr_compactor
    import bist_pkg::*;
#(
    parameter int unsigned         NUM_CHAINS   = 7,
    parameter int unsigned         MISR_W       = DEF_MISR_W,
    parameter logic [MISR_W-1:0]   MISR_POLY    = DEF_MISR_POLY,
    parameter logic [MISR_W-1:0]   MISR_SEED    = '0,
    parameter int unsigned         CHAIN_LEN    = 33,
    parameter int unsigned         NUM_PATTERNS = 1000,
    parameter int unsigned         SKIP_CYCLES  = 33,
    parameter logic [MISR_W-1:0]   GOLDEN_SIG   = '0
) (
    input  logic                   CK,
    input  logic                   COMP_reset_n,
    input  logic                   bist_en,
    input  logic                   scan_en,
    input  logic                   comp_clear,
    input  logic [NUM_CHAINS-1:0]  so_chains,
`ifdef MISR_XMASK_EN
    input  logic [NUM_CHAINS-1:0]  xmask,
`endif
    output logic [MISR_W-1:0]      signature,
    output logic                   bist_done,
    output logic                   bist_pass,
    output logic [CYCLE_CNT_W-1:0] cycle_cnt
);

    localparam logic [63:0] TOTAL_L =
        64'(SKIP_CYCLES) + 64'(NUM_PATTERNS) * 64'(CHAIN_LEN);
    localparam logic [63:0] SKIP_L = 64'(SKIP_CYCLES);
    localparam logic [CYCLE_CNT_W-1:0] TOTAL  = TOTAL_L[CYCLE_CNT_W-1:0];
    localparam logic [CYCLE_CNT_W-1:0] SKIP_C = SKIP_L[CYCLE_CNT_W-1:0];

    if (TOTAL_L >= (64'd1 << CYCLE_CNT_W)) begin : g_total_too_big
        $error("bist_misr_compactor: total cycle count does not fit cycle_cnt");
    end
    if (NUM_CHAINS > MISR_W) begin : g_too_many_chains
        $error("bist_misr_compactor: NUM_CHAINS must not exceed MISR_W");
    end

    bist_state_e            state_q, state_d;
    logic [CYCLE_CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic                   pass_q, pass_d;
    logic                   enable;
    logic                   misr_clr, misr_en;
    logic                   cur_compact, next_compact;
    logic [NUM_CHAINS-1:0]  chain_data;
    logic [MISR_W-1:0]      sig, sig_next;

`ifdef MISR_XMASK_EN
    logic [NUM_CHAINS-1:0]  xmask_q;

    always_ff @(posedge CK or negedge COMP_reset_n) begin
        if (!COMP_reset_n) begin
            xmask_q <= '0;
        end else begin
            xmask_q <= xmask;
        end
    end

    assign chain_data = so_chains & ~xmask_q;
`else
    assign chain_data = so_chains;
`endif

    assign enable  = bist_en & scan_en;
    assign cnt_inc = (cnt_q == TOTAL) ? cnt_q : cnt_q + {{(CYCLE_CNT_W-1){1'b0}}, 1'b1};

    // cur_compact: this cycle lies past the skip window.
    // next_compact: after this cycle the skip window is exhausted.
    if (SKIP_CYCLES == 0) begin : g_no_skip
        assign cur_compact  = 1'b1;
        assign next_compact = 1'b1;
    end else begin : g_skip
        assign cur_compact  = (cnt_q >= SKIP_C);
        assign next_compact = (cnt_inc >= SKIP_C);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pass_d   = pass_q;
        misr_clr = 1'b0;
        misr_en  = 1'b0;
        if (comp_clear) begin
            state_d  = StIdle;
            cnt_d    = '0;
            pass_d   = 1'b0;
            misr_clr = 1'b1;
        end else if (enable) begin
            unique case (state_q)
                StIdle, StSkip, StCompact: begin
                    cnt_d   = cnt_inc;
                    misr_en = cur_compact;
                    if (cnt_inc == TOTAL) begin
                        state_d = StDone;
                        // Compare the value the signature is about to take.
                        pass_d  = ((cur_compact ? sig_next : sig) == GOLDEN_SIG);
                    end else if (next_compact) begin
                        state_d = StCompact;
                    end else begin
                        state_d = StSkip;
                    end
                end
                StDone: begin
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge CK or negedge COMP_reset_n) begin
        if (!COMP_reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
        end
    end

    misr_core #(
        .W    (MISR_W),
        .Poly (MISR_POLY),
        .Seed (MISR_SEED)
    ) u_misr (
        .clk_i      (CK),
        .rst_ni     (COMP_reset_n),
        .clear_i    (misr_clr),
        .en_i       (misr_en),
        .data_i     (MISR_W'(chain_data)),
        .sig_o      (sig),
        .sig_next_o (sig_next)
    );

    assign signature = sig;
    assign bist_done = (state_q == StDone);
    assign bist_pass = pass_q;
    assign cycle_cnt = cnt_q;

endmodule
